// File: rtl/tick_gen_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_multi_pkg
// Brief    : Shared constants for the multi-channel tick generator.
// Revision : 1.0 - initial release
// ============================================================================
package tick_gen_multi_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int CLOCK_HZ  = 12_000_000;

    // Channel roles; higher indices are spare.
    localparam int CH_CPU  = 0;
    localparam int CH_60HZ = 1;

    // Divisor for a desired tick rate, in system clock cycles.
    function automatic logic [DEF_CNT_W-1:0] div_for_rate(input int unsigned rate_hz);
        return DEF_CNT_W'(CLOCK_HZ / rate_hz);
    endfunction

endpackage : tick_gen_multi_pkg
`default_nettype wire

// File: rtl/tick_gen_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_multi_if
// Brief    : Configuration, enable and tick bus of the tick generator.
// Revision : 1.0 - initial release
// ============================================================================
interface tick_gen_multi_if
    import tick_gen_multi_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int CH_W   = 4
);

    logic [NUM_CH-1:0] en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] done;
    logic [CNT_W-1:0]  rd_cnt;

    modport master (
        output en, cfg_we, cfg_ch, cfg_div, cfg_oneshot,
        input  tick, done, rd_cnt
    );

    modport slave (
        input  en, cfg_we, cfg_ch, cfg_div, cfg_oneshot,
        output tick, done, rd_cnt
    );

endinterface : tick_gen_multi_if
`default_nettype wire

// File: rtl/tick_gen_multi_channel.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_multi_channel
// Brief    : One tick channel: down-counter, periodic/one-shot mode, tick reg.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen_multi_channel
    import tick_gen_multi_pkg::*;
#(
    parameter int               CNT_W           = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEFAULT_DIV     = '0,
    parameter logic             DEFAULT_ONESHOT = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_wr,
    input  wire logic [CNT_W-1:0] i_wr_div,
    input  wire logic             i_wr_oneshot,
    output logic                  o_tick,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_cnt
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_oneshot;
    logic             r_armed;
    logic             r_done;
    logic             r_tick;

    // Counter start value: D-1 so that the period is exactly D; a zero divisor parks at 0.
    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= DEFAULT_DIV;
            r_cnt     <= reload(DEFAULT_DIV);
            r_oneshot <= DEFAULT_ONESHOT;
            r_armed   <= 1'b1;
            r_done    <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_wr) begin
            // A write retriggers the channel and beats a coincident terminal count.
            r_div     <= i_wr_div;
            r_cnt     <= reload(i_wr_div);
            r_oneshot <= i_wr_oneshot;
            r_armed   <= 1'b1;
            r_done    <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= reload(r_div);
            r_tick <= 1'b0;
        end else if (r_armed && (r_div != '0)) begin
            if (r_cnt == '0) begin
                r_tick <= 1'b1;
                r_cnt  <= reload(r_div);
                if (r_oneshot) begin
                    r_armed <= 1'b0;
                    r_done  <= 1'b1;
                end
            end else begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;
    assign o_done = r_done;
    assign o_cnt  = r_cnt;

endmodule : tick_gen_multi_channel
`default_nettype wire

// File: rtl/tick_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_multi
// Brief    : NUM_CH independent programmable tick channels with config decode.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen_multi
    import tick_gen_multi_pkg::*;
#(
    parameter int                      NUM_CH          = 2,
    parameter int                      CNT_W           = DEF_CNT_W,
    parameter int                      CH_W            = 4,
    parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIVS    = {32'd200000, 32'd1666666},
    parameter logic [NUM_CH-1:0]       DEFAULT_ONESHOT = '0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    tick_gen_multi_if.slave  bus
);

    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_done;
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [CNT_W-1:0]  w_rd_cnt;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            // Out-of-range channel numbers match no decoder and are dropped.
            assign w_wr[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

            tick_gen_multi_channel #(
                .CNT_W           (CNT_W),
                .DEFAULT_DIV     (DEFAULT_DIVS[i*CNT_W +: CNT_W]),
                .DEFAULT_ONESHOT (DEFAULT_ONESHOT[i])
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .i_en         (bus.en[i]),
                .i_wr         (w_wr[i]),
                .i_wr_div     (bus.cfg_div),
                .i_wr_oneshot (bus.cfg_oneshot),
                .o_tick       (w_tick[i]),
                .o_done       (w_done[i]),
                .o_cnt        (w_cnt[i])
            );
        end
    endgenerate

    always_comb begin
        w_rd_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cfg_ch == CH_W'(i)) begin
                w_rd_cnt = w_cnt[i];
            end
        end
    end

    assign bus.tick   = w_tick;
    assign bus.done   = w_done;
    assign bus.rd_cnt = w_rd_cnt;

endmodule : tick_gen_multi
`default_nettype wire
